// File: rtl/rst_seq_ctrl.sv
// ============================================================================
// Module      : rst_seq_ctrl
// Description : Multi-channel reset sequencer: synchronises the board reset,
//               stretches it, then releases channels one by one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq_ctrl #(
    parameter int NUM_CH         = 3,
    parameter int NUM_STAGES     = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int SEQ_GAP        = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Sw_rst_req,
    input  logic [NUM_CH-1:0] Ch_hold,
    output logic [NUM_CH-1:0] Sync_rst_n,
    output logic              Rst_done
);

    localparam int c_CNT_MAX = (STRETCH_CYCLES > SEQ_GAP) ? STRETCH_CYCLES : SEQ_GAP;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [c_CNT_W-1:0] c_STRETCH_LAST = c_CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST     = c_CNT_W'(SEQ_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE      = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST     = c_IDX_W'(NUM_CH - 1);
    localparam logic               c_SINGLE_CH    = (NUM_CH == 1);

    localparam logic [1:0] c_ST_ASSERT  = 2'd0;
    localparam logic [1:0] c_ST_RELEASE = 2'd1;
    localparam logic [1:0] c_ST_DONE    = 2'd2;

    logic [NUM_STAGES-1:0] r_sync_chain;
    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_done;
    logic [NUM_CH-1:0]     r_slot_passed;
    logic [NUM_CH-1:0]     r_rst_n;

    logic                  w_sync_out;
    logic                  w_stretch_hit;
    logic                  w_gap_hit;
    logic [NUM_CH-1:0]     w_rel_now;

    // Deassertion is shifted in; assertion clears the chain asynchronously.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync_chain <= '0;
        end else begin
            r_sync_chain <= {r_sync_chain[NUM_STAGES-2:0], 1'b1};
        end
    end

    assign w_sync_out    = r_sync_chain[NUM_STAGES-1];
    assign w_stretch_hit = (r_state == c_ST_ASSERT) && w_sync_out && (r_cnt == c_STRETCH_LAST);
    assign w_gap_hit     = (r_state == c_ST_RELEASE) && (r_cnt == c_GAP_LAST);

    // One-hot "this channel's slot is now" strobe.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_rel
        if (k == 0) begin : g_first
            assign w_rel_now[k] = w_stretch_hit;
        end else begin : g_next
            assign w_rel_now[k] = w_gap_hit && (r_idx == c_IDX_W'(k));
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= c_ST_ASSERT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else if (Sw_rst_req) begin
            r_state <= c_ST_ASSERT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_ASSERT: begin
                    if (w_stretch_hit) begin
                        r_cnt <= '0;
                        if (c_SINGLE_CH) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_ST_RELEASE;
                            r_idx   <= c_IDX_ONE;
                        end
                    end else if (w_sync_out) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_RELEASE: begin
                    if (w_gap_hit) begin
                        r_cnt <= '0;
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_DONE;
                end
                default: begin
                    r_state <= c_ST_ASSERT;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // A slot elapses even for a held channel; the hold only masks the output.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_slot_passed <= '0;
            r_rst_n       <= '0;
        end else if (Sw_rst_req) begin
            r_slot_passed <= '0;
            r_rst_n       <= '0;
        end else begin
            r_slot_passed <= r_slot_passed | w_rel_now;
            r_rst_n       <= (r_slot_passed | w_rel_now) & ~Ch_hold;
        end
    end

    assign Sync_rst_n = r_rst_n;
    assign Rst_done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
// ============================================================================
// Module      : tb_rst_seq_ctrl
// Description : Directed scoreboard bench for rst_seq_ctrl (3-channel default
//               instance plus a 1-channel, 3-stage, 1-cycle-stretch instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_seq_ctrl;

    logic       Clk;
    logic       Reset_n;
    logic       sw0;
    logic [2:0] hold0;
    logic [2:0] sync0;
    logic       done0;
    logic       sw1;
    logic [0:0] hold1;
    logic [0:0] sync1;
    logic       done1;

    int cyc;
    int checks;
    int errors;

    typedef struct {
        int         edge_no;
        int         dut;
        logic [2:0] sync;
        logic       done;
        string      tag;
    } exp_t;

    exp_t sb[$];

    rst_seq_ctrl #(
        .NUM_CH         (3),
        .NUM_STAGES     (2),
        .STRETCH_CYCLES (16),
        .SEQ_GAP        (4)
    ) u_dut3 (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Sw_rst_req (sw0),
        .Ch_hold    (hold0),
        .Sync_rst_n (sync0),
        .Rst_done   (done0)
    );

    rst_seq_ctrl #(
        .NUM_CH         (1),
        .NUM_STAGES     (3),
        .STRETCH_CYCLES (1),
        .SEQ_GAP        (4)
    ) u_dut1 (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Sw_rst_req (sw1),
        .Ch_hold    (hold1),
        .Sync_rst_n (sync1),
        .Rst_done   (done1)
    );

    always #5 Clk = ~Clk;

    task automatic push(input int e, input int d, input logic [2:0] s, input logic dn, input string tag);
        exp_t x;
        x.edge_no = e;
        x.dut     = d;
        x.sync    = s;
        x.done    = dn;
        x.tag     = tag;
        sb.push_back(x);
    endtask

    task automatic drain();
        logic [2:0] obs_s;
        logic       obs_d;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].edge_no == cyc) begin
                if (sb[i].dut == 0) begin
                    obs_s = sync0;
                    obs_d = done0;
                end else begin
                    obs_s = {2'b00, sync1};
                    obs_d = done1;
                end
                checks++;
                assert (obs_s === sb[i].sync && obs_d === sb[i].done) else begin
                    errors++;
                    $error("FAIL %s edge=%0d dut%0d observed sync=%b done=%b expected sync=%b done=%b",
                           sb[i].tag, cyc, sb[i].dut, obs_s, obs_d, sb[i].sync, sb[i].done);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        cyc++;
        #1;
        drain();
    endtask

    task automatic run_to(input int e);
        while (cyc < e) step();
    endtask

    // Short low pulse between edges; outputs must clear without a clock edge.
    task automatic reset_pulse(input string tag);
        Reset_n = 1'b0;
        #1;
        push(cyc, 0, 3'b000, 1'b0, tag);
        push(cyc, 1, 3'b000, 1'b0, tag);
        drain();
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        Clk     = 1'b0;
        Reset_n = 1'b0;
        sw0     = 1'b0;
        hold0   = 3'b000;
        sw1     = 1'b0;
        hold1   = 1'b0;
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        #2;
        Reset_n = 1'b1;

        // Power-on sequence, edges counted from the first edge with Reset_n high
        for (int e = 1; e <= 17; e++) push(e, 0, 3'b000, 1'b0, "pwr_held");
        push(3,  1, 3'b000, 1'b0, "one_ch_before");
        push(4,  1, 3'b001, 1'b1, "one_ch_release");
        push(18, 0, 3'b001, 1'b0, "pwr_bit0");
        push(21, 0, 3'b001, 1'b0, "pwr_gap");
        push(22, 0, 3'b011, 1'b0, "pwr_bit1");
        push(25, 0, 3'b011, 1'b0, "pwr_pre_bit2");
        push(26, 0, 3'b111, 1'b1, "pwr_bit2_done");
        push(28, 0, 3'b111, 1'b1, "done_stable");
        run_to(28);

        // Async reset in DONE, then again mid-sequence at relative edge 20
        reset_pulse("async_in_done");
        push(45, 0, 3'b000, 1'b0, "rst1_held");
        push(46, 0, 3'b001, 1'b0, "rst1_bit0");
        push(48, 0, 3'b001, 1'b0, "mid_before_pulse");
        run_to(48);
        reset_pulse("async_mid_seq");
        push(65, 0, 3'b000, 1'b0, "rst2_held");
        push(66, 0, 3'b001, 1'b0, "rst2_bit0");
        push(70, 0, 3'b011, 1'b0, "rst2_bit1");
        push(73, 0, 3'b011, 1'b0, "rst2_pre_bit2");
        push(74, 0, 3'b111, 1'b1, "rst2_done");
        run_to(80);

        // Software reset for three edges (81..83) while in DONE
        sw0 = 1'b1;
        push(81,  0, 3'b000, 1'b0, "sw_first_edge");
        push(83,  0, 3'b000, 1'b0, "sw_last_edge");
        push(98,  0, 3'b000, 1'b0, "sw_stretch");
        push(99,  0, 3'b001, 1'b0, "sw_bit0");
        push(103, 0, 3'b011, 1'b0, "sw_bit1");
        push(106, 0, 3'b011, 1'b0, "sw_pre_bit2");
        push(107, 0, 3'b111, 1'b1, "sw_done");
        run_to(83);
        sw0 = 1'b0;
        run_to(109);

        // Software reset sampled on the same edge as the bit1 release (130)
        sw0 = 1'b1;
        push(110, 0, 3'b000, 1'b0, "sw2_clear");
        push(126, 0, 3'b001, 1'b0, "sw2_bit0");
        push(129, 0, 3'b001, 1'b0, "sw2_before_clash");
        push(130, 0, 3'b000, 1'b0, "sw_beats_release");
        step();
        sw0 = 1'b0;
        run_to(129);
        sw0 = 1'b1;
        step();
        sw0 = 1'b0;
        push(145, 0, 3'b000, 1'b0, "sw3_held");
        push(146, 0, 3'b001, 1'b0, "sw3_bit0");
        push(150, 0, 3'b011, 1'b0, "sw3_bit1");
        push(154, 0, 3'b111, 1'b1, "sw3_done");
        run_to(156);

        // Channel 1 held from reset; slot passes without releasing it
        hold0 = 3'b010;
        reset_pulse("async_hold_start");
        push(159, 1, 3'b000, 1'b0, "one_ch_rst_before");
        push(160, 1, 3'b001, 1'b1, "one_ch_rst_release");
        push(173, 0, 3'b000, 1'b0, "hold_stretch");
        push(174, 0, 3'b001, 1'b0, "hold_bit0");
        push(178, 0, 3'b001, 1'b0, "hold_blocks_bit1");
        push(182, 0, 3'b101, 1'b1, "hold_done_ignores");
        push(186, 0, 3'b101, 1'b1, "hold_still_held");
        run_to(186);
        hold0 = 3'b000;
        push(187, 0, 3'b111, 1'b1, "hold_drop");
        push(196, 0, 3'b111, 1'b1, "hold_dropped_stable");
        run_to(196);
        hold0 = 3'b010;
        push(197, 0, 3'b101, 1'b1, "hold_reraise");
        push(199, 0, 3'b101, 1'b1, "hold_reraise_stable");
        run_to(200);
        hold1 = 1'b1;
        push(201, 1, 3'b000, 1'b1, "one_ch_hold_done");
        run_to(202);

        if (sb.size() != 0) begin
            for (int i = 0; i < sb.size(); i++) begin
                checks++;
                errors++;
                $display("FAIL %s never reached edge=%0d", sb[i].tag, sb[i].edge_no);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
